// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: time-shares one external combinational 64-bit ALU between
// NUM_REQ requesters. A round-robin arbiter picks a requester, its instruction
// and operands are registered onto the ALU inputs and held for EXEC_CYCLES
// cycles, then the ALU result is captured into a response register that is
// held under valid/ready backpressure.
//
// Parameters
//   NUM_REQ      number of requesters (2..4)
//   ID_W         width of rsp_id (>= clog2(NUM_REQ), min 1)
//   EXEC_CYCLES  cycles the operands are held before capture (1..15)
//
// Ports
//   clk, rst_n                clock, synchronous active-low reset
//   req_valid / req_ready     per-requester handshake (ready is one-hot or 0)
//   req_instruction           packed NUM_REQ x 32-bit instructions
//   req_in1 / req_in2         packed NUM_REQ x 64-bit operands
//   alu_instruction/in1/in2   registered ALU inputs
//   alu_out / alu_zero        ALU result and zero flag (combinational)
//   rsp_valid / rsp_ready     response handshake
//   rsp_id/rsp_out/rsp_zero   owner index, captured result and zero flag
//   busy                      registered, high whenever not idle
module alu_share_ctrl #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ID_W        = 1,
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*32-1:0]   req_instruction,
  input  logic [NUM_REQ*64-1:0]   req_in1,
  input  logic [NUM_REQ*64-1:0]   req_in2,
  output logic [31:0]             alu_instruction,
  output logic [63:0]             alu_in1,
  output logic [63:0]             alu_in2,
  input  logic [63:0]             alu_out,
  input  logic                    alu_zero,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [63:0]             rsp_out,
  output logic                    rsp_zero,
  output logic                    busy
);

  localparam int unsigned SEL_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned DATA_W  = 64;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [ID_W-1:0]    last_q;
  logic [ID_W-1:0]    grant;
  logic               grant_found;
  logic               can_accept;
  logic               accept;
  logic               exec_done;
  logic [INSTR_W-1:0] sel_instruction;
  logic [DATA_W-1:0]  sel_in1;
  logic [DATA_W-1:0]  sel_in2;

  // Requester index examined at position off of the round-robin scan.
  function automatic logic [SEL_W-1:0] scan_idx(input logic [ID_W-1:0] base,
                                                input int unsigned    off);
    int unsigned pos;
    pos = (32'(base) + off + 32'd1) % NUM_REQ;
    return SEL_W'(pos);
  endfunction

  // Round-robin arbiter: first valid requester after the last winner.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && req_valid[scan_idx(last_q, k)]) begin
        grant       = ID_W'(scan_idx(last_q, k));
        grant_found = 1'b1;
      end
    end
  end

  // Payload select for the granted requester.
  always_comb begin
    sel_instruction = '0;
    sel_in1         = '0;
    sel_in2         = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant == ID_W'(k)) begin
        sel_instruction = req_instruction[k*INSTR_W +: INSTR_W];
        sel_in1         = req_in1[k*DATA_W +: DATA_W];
        sel_in2         = req_in2[k*DATA_W +: DATA_W];
      end
    end
  end

  // A new operation can enter when idle or when the held response leaves.
  assign can_accept = (state_q == ST_IDLE) ||
                      ((state_q == ST_RESP) && rsp_ready);

  // One-hot accept; held low during reset so no requester sees a phantom grant.
  always_comb begin
    req_ready = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      req_ready[k] = rst_n && can_accept && grant_found && (grant == ID_W'(k));
    end
  end

  assign accept    = |req_ready;
  assign exec_done = (state_q == ST_EXEC) && (cnt_q == '0);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (exec_done) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = accept ? ST_EXEC : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register plus the status flags derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rsp_valid <= (state_d == ST_RESP);
      busy      <= (state_d != ST_IDLE);
    end
  end

  // Arbitration pointer and evaluation counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= ID_W'(NUM_REQ - 1);
      cnt_q  <= '0;
    end else begin
      if (accept) begin
        last_q <= grant;
        cnt_q  <= CNT_W'(EXEC_CYCLES - 1);
      end else if ((state_q == ST_EXEC) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // ALU operand registers: only change on accept, so they are stable in EXEC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_instruction <= '0;
      alu_in1         <= '0;
      alu_in2         <= '0;
      rsp_id          <= '0;
    end else if (accept) begin
      alu_instruction <= sel_instruction;
      alu_in1         <= sel_in1;
      alu_in2         <= sel_in2;
      rsp_id          <= grant;
    end
  end

  // Result capture at the end of evaluation; held through RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_out  <= '0;
      rsp_zero <= 1'b0;
    end else if (exec_done) begin
      rsp_out  <= alu_out;
      rsp_zero <= alu_zero;
    end
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Arbiter and sequencer that shares one 64-bit combinational `alu` between up to four requesters, for example the execute stage and a branch/address helper. It arbitrates round-robin, registers the winner's instruction and operands onto the ALU inputs, and holds them for a programmable number of evaluation cycles. It then captures `out` and `zero` into a response register held under valid/ready backpressure.

## Interface
- `NUM_REQ`, default 2: number of requesters, legal range 2..4.
- `ID_W`, default 1: width of `rsp_id`; must be ≥ clog2(`NUM_REQ`), minimum 1.
- `EXEC_CYCLES`, default 1: cycles the operands are held before result capture, legal range 1..15.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `req_valid` input `NUM_REQ`: per-requester request valid.
- `req_ready` output `NUM_REQ`: per-requester accept, one-hot or zero.
- `req_instruction` input `NUM_REQ`*32: packed; requester i occupies bits [32i+31:32i].
- `req_in1` input `NUM_REQ`*64: packed first operands.
- `req_in2` input `NUM_REQ`*64: packed second operands.
- `alu_instruction` output 32: registered instruction to the ALU.
- `alu_in1` output 64: registered first operand to the ALU.
- `alu_in2` output 64: registered second operand to the ALU.
- `alu_out` input 64: ALU result, combinational from the `alu_*` outputs.
- `alu_zero` input 1: ALU zero flag.
- `rsp_valid` output 1: response valid.
- `rsp_ready` input 1: response consumer ready.
- `rsp_id` output `ID_W`: index of the requester that owns the response.
- `rsp_out` output 64: captured ALU result.
- `rsp_zero` output 1: captured ALU zero flag.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- **States**
  - IDLE: no operation held.
  - EXEC: operands on the ALU; cycle counter `cnt` running.
  - RESP: result held on `rsp_*`.
- **Acceptance**
  - `can_accept` = (state==IDLE) or (state==RESP and `rsp_ready`).
  - The arbiter picks grant g, the first valid requester searching from (`last`+1) mod `NUM_REQ` upward with wrap.
  - `req_ready[g]` = `can_accept` and `req_valid[g]`. All other `req_ready` bits are 0.
  - `req_ready` is combinational from `req_valid` and state.
  - `req_ready` is forced to 0 while `rst_n`=0.
- **On accept (edge)**
  - `alu_instruction`, `alu_in1`, `alu_in2` load the slices of requester g; `rsp_id` is also loaded with g.
  - `last` ← g; `cnt` ← `EXEC_CYCLES`-1; state → EXEC.
- **EXEC**
  - The `alu_*` outputs are held constant.
  - While `cnt`≠0, `cnt` decrements each edge.
  - At the edge where `cnt`==0: `rsp_out` ← `alu_out`, `rsp_zero` ← `alu_zero`, state → RESP.
- **RESP**
  - `rsp_valid`=1. `rsp_id`, `rsp_out` and `rsp_zero` are held stable until the handshake (`rsp_valid` and `rsp_ready`).
  - On handshake with a new accept on the same edge: state → EXEC.
  - On handshake with no accept: state → IDLE.
- **Pass-through**
  - The instruction goes to the ALU unmodified; the block never decodes opcode, funct3 or funct7.
  - Operands are 64-bit two's complement, passed through with no width change.
- **Requester protocol**
  - Once `req_valid[i]` is raised, it must stay high with a stable payload until `req_ready[i]`.
  - A requester dropping valid early is a protocol violation; no recovery is defined.
- **Fairness**
  - A continuously valid requester is granted within `NUM_REQ` grants.
- **Reset**
  - Asserting `rst_n`=0 in any state returns the block to IDLE at the next edge and discards any in-flight operation; no response is produced for it.
  - `last` resets to `NUM_REQ`-1, so requester 0 has first priority.
  - `cnt`, `rsp_id`, `rsp_out`, `rsp_zero` and all `alu_*` outputs reset to 0; `rsp_valid` and `busy` reset to 0.

## Timing
- Accept at edge k:
  - the `alu_*` outputs are valid after edge k;
  - the result is captured at edge k+`EXEC_CYCLES`;
  - `rsp_valid` is high after edge k+`EXEC_CYCLES`.
- Minimum spacing between accepts is `EXEC_CYCLES`+1 cycles, with `rsp_ready` held high.
- `rsp_valid` falls on the handshake edge unless a new operation completes in the same edge; that cannot happen, because `EXEC_CYCLES` ≥ 1.
- `busy` is registered and equals (state≠IDLE).
- The ALU critical path (`alu_*` regs → alu → `rsp_out`) is one full cycle at `EXEC_CYCLES`=1. Larger values give a multicycle path constraint of `EXEC_CYCLES`.

## Test plan
- **Reset:** `rst_n`=0 for 3 cycles with `req_valid`=2'b11 → `req_ready`=0, `rsp_valid`=0, all `alu_*`=0, `busy`=0. After release, the first grant goes to requester 0.
- **Single request:** requester 1 sends `add` 0x002081B3, in1=5, in2=7, `EXEC_CYCLES`=1 → `req_ready[1]` high one cycle; `rsp_valid` one cycle after accept with `rsp_out`=12, `rsp_zero`=0, `rsp_id`=1.
- **Contention:** both valid continuously, `rsp_ready`=1; requester 0 sends `sub` 0x402081B3 with 7,7 and requester 1 sends `add` with 3,4 → grants alternate 0,1,0,1 every 2 cycles. Responses are (id0, 0, zero=1) and (id1, 7, zero=0).
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_*` stable, `req_ready`=0, no grant. Raise `rsp_ready` → handshake and the next accept occur on the same edge, and `rsp_valid` drops.
- **Long evaluation:** `EXEC_CYCLES`=3, `sll` with in1=1, in2=63 → the `alu_*` outputs are stable for 3 cycles. `rsp_valid` is high 3 edges after accept with `rsp_out`=0x8000000000000000.
- **Reset mid-operation:** `rst_n`=0 for 1 cycle during EXEC → the next cycle shows IDLE, `rsp_valid`=0, `busy`=0. No stale response appears; the next grant goes to requester 0.
